// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the ALU op sequencer: opcodes, ALU function selects,
// FSM states and flag bit positions. MUL_EN adds the multiply opcode and loop state.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NEG  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_MOVX = 4'b0110;
  localparam logic [3:0] OP_MOVY = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  localparam logic [2:0] FSEL_ADD   = 3'b001;
  localparam logic [2:0] FSEL_SUB   = 3'b010;
  localparam logic [2:0] FSEL_NEG   = 3'b011;
  localparam logic [2:0] FSEL_NOT   = 3'b100;
  localparam logic [2:0] FSEL_OR    = 3'b101;
  localparam logic [2:0] FSEL_PASSX = 3'b110;
  localparam logic [2:0] FSEL_PASSY = 3'b111;
  localparam logic [2:0] FSEL_IDLE  = 3'b110;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_S = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_X,
    ST_RD_Y,
    ST_EXEC,
    ST_WB,
    ST_ERR
`ifdef MUL_EN
    , ST_MUL_LOOP
`endif
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
`ifdef MUL_EN
    return (op >= OP_ADD) && (op <= OP_MUL);
`else
    return (op >= OP_ADD) && (op <= OP_MOVY);
`endif
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// C/Z/V/S status register. Z and S always follow the ALU; C and V are loaded,
// cleared or held depending on the opcode being executed.
module alu_flag_reg
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_op,
  input  logic       i_c,
  input  logic       i_zf,
  input  logic       i_v,
  input  logic       i_s,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (i_load) begin
      r_flags[FLAG_Z] <= i_zf;
      r_flags[FLAG_S] <= i_s;
      case (i_op)
        OP_ADD: begin
          r_flags[FLAG_C] <= i_c;
          r_flags[FLAG_V] <= i_v;
        end
        OP_NEG, OP_NOT, OP_OR, OP_MUL: begin
          r_flags[FLAG_C] <= 1'b0;
          r_flags[FLAG_V] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller sequencing one register-register ALU instruction:
// read X, read Y, execute, write back. Define MUL_EN for the shift-add multiply.
module alu_op_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_xy,
  output logic [DATA_W-1:0] alu_y,
  output logic [2:0]        alu_fsel,
  input  logic [DATA_W-1:0] alu_z,
  input  logic              alu_c,
  input  logic              alu_zf,
  input  logic              alu_v,
  input  logic              alu_s,
  output logic [3:0]        flags,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic [3:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_z;
  logic              r_ready;
  logic              r_we;
  logic              r_done;
  logic              r_err;

  logic              w_mul_last;
  logic              w_flag_load;
  logic              w_flag_zf;
  logic              w_flag_s;

`ifdef MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mult;
  logic [CNT_W-1:0]  r_cnt;

  assign w_mul_last = (r_state == ST_MUL_LOOP) && (r_cnt == CNT_W'(DATA_W - 1));
  // The multiply result's Z/S come from the final accumulator, not the ALU's flag outputs.
  assign w_flag_zf  = w_mul_last ? (alu_z == '0) : alu_zf;
  assign w_flag_s   = w_mul_last ? alu_z[DATA_W-1] : alu_s;
`else
  assign w_mul_last = 1'b0;
  assign w_flag_zf  = alu_zf;
  assign w_flag_s   = alu_s;
`endif

  assign w_flag_load = (r_state == ST_EXEC) || w_mul_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_rs    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef MUL_EN
      r_acc   <= '0;
      r_mcand <= '0;
      r_mult  <= '0;
      r_cnt   <= '0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_op    <= instr_op;
            r_rd    <= instr_rd;
            r_rs    <= instr_rs;
            r_ready <= 1'b0;
            if (op_is_legal(instr_op)) begin
              r_state <= ST_RD_X;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        ST_RD_X: begin
          r_x     <= rf_rdata;
          r_state <= ST_RD_Y;
        end
        ST_RD_Y: begin
          r_y     <= rf_rdata;
          r_state <= ST_EXEC;
`ifdef MUL_EN
          if (r_op == OP_MUL) begin
            r_acc   <= '0;
            r_mcand <= r_x;
            r_mult  <= rf_rdata;
            r_cnt   <= '0;
            r_state <= ST_MUL_LOOP;
          end
`endif
        end
        ST_EXEC: begin
          r_z     <= alu_z;
          r_we    <= 1'b1;
          r_done  <= 1'b1;
          r_state <= ST_WB;
        end
`ifdef MUL_EN
        ST_MUL_LOOP: begin
          r_acc   <= alu_z;
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_z     <= alu_z;
            r_we    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_WB;
          end
        end
`endif
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: every output of this always_comb gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    rf_raddr = '0;
    alu_fsel = FSEL_IDLE;
    alu_xy   = '0;
    alu_y    = '0;
    case (r_state)
      ST_RD_X: rf_raddr = r_rd;
      ST_RD_Y: rf_raddr = r_rs;
      ST_EXEC: begin
        alu_fsel = r_op[2:0];
        alu_xy   = r_x;
        alu_y    = r_y;
      end
`ifdef MUL_EN
      ST_MUL_LOOP: begin
        alu_fsel = FSEL_ADD;
        alu_xy   = r_acc;
        alu_y    = r_mult[0] ? r_mcand : '0;
      end
`endif
      default: ;
    endcase
  end

  alu_flag_reg u_flags (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_flag_load),
    .i_op    (r_op),
    .i_c     (alu_c),
    .i_zf    (w_flag_zf),
    .i_v     (alu_v),
    .i_s     (w_flag_s),
    .o_flags (flags)
  );

  assign instr_ready = r_ready;
  assign rf_we       = r_we;
  assign rf_waddr    = r_rd;
  assign rf_wdata    = r_z;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: bench-side RF and ALU models,
// directed corner cases plus randomized instructions against a reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = '0;
  logic [2:0]  instr_rd = '0;
  logic [2:0]  instr_rs = '0;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] alu_xy;
  logic [15:0] alu_y;
  logic [2:0]  alu_fsel;
  logic [15:0] alu_z;
  logic        alu_c;
  logic        alu_zf;
  logic        alu_v;
  logic        alu_s;
  logic [3:0]  flags;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [3:0] flags_m = '0;

  logic [15:0] rf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs    (instr_rs),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .alu_xy      (alu_xy),
    .alu_y       (alu_y),
    .alu_fsel    (alu_fsel),
    .alu_z       (alu_z),
    .alu_c       (alu_c),
    .alu_zf      (alu_zf),
    .alu_v       (alu_v),
    .alu_s       (alu_s),
    .flags       (flags),
    .done        (done),
    .err         (err)
  );

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  // ALU model; C/V are deliberately set on ops where the controller must ignore them.
  always_comb begin
    logic [16:0] sum;
    sum   = '0;
    alu_z = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_fsel)
      3'd1: begin
        sum   = {1'b0, alu_xy} + {1'b0, alu_y};
        alu_z = sum[15:0];
        alu_c = sum[16];
        alu_v = (alu_xy[15] == alu_y[15]) && (alu_z[15] != alu_xy[15]);
      end
      3'd2: begin
        alu_z = alu_xy - alu_y;
        alu_c = alu_xy < alu_y;
        alu_v = (alu_xy[15] != alu_y[15]) && (alu_z[15] != alu_xy[15]);
      end
      3'd3: begin alu_z = -alu_xy;        alu_c = 1'b1; alu_v = 1'b1; end
      3'd4: begin alu_z = ~alu_xy;        alu_c = 1'b1; alu_v = 1'b1; end
      3'd5: begin alu_z = alu_xy | alu_y; alu_c = 1'b1; alu_v = 1'b1; end
      3'd6: begin alu_z = alu_xy;         alu_c = 1'b1; alu_v = 1'b1; end
      3'd7: begin alu_z = alu_y;          alu_c = 1'b1; alu_v = 1'b1; end
      default: ;
    endcase
    alu_zf = (alu_z == 16'h0000);
    alu_s  = alu_z[15];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural result of one instruction, flags given as {C,Z,V,S}.
  function automatic void ref_model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                                    input logic [3:0] f_in, output bit legal,
                                    output logic [15:0] res, output logic [3:0] f_out);
    int unsigned u;
    int          s;
    logic        c;
    logic        v;
    legal = 1'b1;
    c     = f_in[3];
    v     = f_in[1];
    res   = '0;
    case (op)
      4'd1: begin
        u   = int'(x) + int'(y);
        res = u[15:0];
        c   = (u > 32'd65535);
        s   = int'($signed(x)) + int'($signed(y));
        v   = (s > 32767) || (s < -32768);
      end
      4'd2: res = x - y;
      4'd3: begin res = -x;    c = 1'b0; v = 1'b0; end
      4'd4: begin res = ~x;    c = 1'b0; v = 1'b0; end
      4'd5: begin res = x | y; c = 1'b0; v = 1'b0; end
      4'd6: res = x;
      4'd7: res = y;
`ifdef MUL_EN
      4'd8: begin
        u   = int'(x) * int'(y);
        res = u[15:0];
        c   = 1'b0;
        v   = 1'b0;
      end
`endif
      default: legal = 1'b0;
    endcase
    f_out = legal ? {c, res == 16'h0000, v, res[15]} : f_in;
  endfunction

  task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge where it is idle again.
  // With hold set, instr_valid stays high afterwards so the next call issues back-to-back.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input bit hold);
    logic [15:0] x, y, res;
    logic [3:0]  f_exp;
    bit          legal;
    int          lat, last, we_cnt;
    x = rf[rd];
    y = rf[rs];
    ref_model(op, x, y, flags_m, legal, res, f_exp);
    lat    = (legal && op == 4'd8) ? 19 : 4;
    last   = legal ? lat + 1 : 2;
    we_cnt = 0;
    check("ready_at_T", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        instr_valid = hold;
        instr_op    = 4'($urandom);
        instr_rd    = 3'($urandom);
        instr_rs    = 3'($urandom);
        check("err_T1", err, !legal);
      end
      if (k < last) check("busy_not_ready", instr_ready, 0);
      if (rf_we) we_cnt++;
      if (legal) begin
        if (k == 1) check("raddr_rd", rf_raddr, rd);
        if (k == 2) check("raddr_rs", rf_raddr, rs);
        if (k == 3) begin
          check("exec_fsel", alu_fsel, (op == 4'd8) ? 3'd1 : op[2:0]);
          check("exec_xy", alu_xy, (op == 4'd8) ? 16'h0000 : x);
          if (op != 4'd8) check("exec_y", alu_y, y);
        end
        if (rf_we) begin
          check("wb_cycle", k, lat);
          check("wb_waddr", rf_waddr, rd);
          check("wb_wdata", rf_wdata, res);
          check("wb_done", done, 1);
          check("wb_flags", flags, f_exp);
        end
      end
    end
    check("ready_after", instr_ready, 1);
    check("we_count", we_cnt, legal ? 1 : 0);
    check("flags_after", flags, f_exp);
    if (legal) check("rf_written", rf[rd], res);
    flags_m = f_exp;
  endtask

  task automatic reset_mid_exec(input logic [2:0] rd, input logic [2:0] rs);
    logic [15:0] old;
    old         = rf[rd];
    instr_valid = 1'b1;
    instr_op    = 4'd1;
    instr_rd    = rd;
    instr_rs    = rs;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_exec", alu_fsel, 3'd1);
    reset = 1'b0;
    #1;
    check("rst_we", rf_we, 0);
    check("rst_flags", flags, 0);
    check("rst_ready", instr_ready, 1);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_we", rf_we, 0);
      check("rst_hold_ready", instr_ready, 1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", instr_ready, 1);
    check("rel_we", rf_we, 0);
    check("rel_flags", flags, 0);
    check("rel_rf_kept", rf[rd], old);
    flags_m = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] corner [6];
    logic [3:0]  op;
    bit          h, prev_hold;
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
    corner[3] = 16'h7FFF; corner[4] = 16'h0001; corner[5] = 16'h0100;

    repeat (2) @(negedge clk);
    check("reset_ready", instr_ready, 1);
    check("reset_we", rf_we, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_flags", flags, 0);
    check("reset_fsel", alu_fsel, 3'b110);
    check("reset_raddr", rf_raddr, 0);
    check("reset_xy", alu_xy, 0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'(i * 16'h1111));

    set_reg(3'd1, 16'h7FFF);
    set_reg(3'd2, 16'h0001);
    run_instr(4'd1, 3'd1, 3'd2, 1'b0);
    check("add_ovf_flags", flags, 4'b0011);
    set_reg(3'd3, 16'hFFFF);
    set_reg(3'd4, 16'h0001);
    run_instr(4'd1, 3'd3, 3'd4, 1'b0);
    check("add_carry_flags", flags, 4'b1100);
    set_reg(3'd5, 16'h00FF);
    run_instr(4'd4, 3'd5, 3'd5, 1'b0);
    check("not_result", rf[5], 16'hFF00);
    check("not_flags", flags, 4'b0001);
    run_instr(4'd0, 3'd1, 3'd2, 1'b0);
    run_instr(4'hF, 3'd6, 3'd7, 1'b0);

    set_reg(3'd6, 16'h0003);
    set_reg(3'd7, 16'h0005);
    run_instr(4'd8, 3'd6, 3'd7, 1'b0);
    set_reg(3'd1, 16'h0100);
    set_reg(3'd2, 16'h0100);
    run_instr(4'd8, 3'd1, 3'd2, 1'b0);

    reset_mid_exec(3'd3, 3'd4);
    run_instr(4'd1, 3'd3, 3'd4, 1'b0);

    run_instr(4'd1, 3'd1, 3'd2, 1'b1);
    run_instr(4'd8, 3'd6, 3'd7, 1'b1);
    run_instr(4'd2, 3'd3, 3'd4, 1'b0);

    prev_hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!prev_hold && ($urandom % 3 == 0)) begin
        if ($urandom % 2 == 0) set_reg(3'($urandom), corner[$urandom % 6]);
        else set_reg(3'($urandom), 16'($urandom));
      end
      if ($urandom % 5 == 0) op = 4'($urandom);
      else op = 4'($urandom_range(1, 8));
      h = ($urandom % 4 == 0) && (i != 59);
      run_instr(op, 3'($urandom), 3'($urandom), h);
      prev_hold = h;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
